// File: rtl/pomdp_pkg.sv
// rtl/pomdp_pkg.sv - shared types and constants for the POMDP episode controller
package pomdp_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DECIDE   = 3'd1,
        S_ENV      = 3'd2,
        S_BELIEF   = 3'd3,
        S_STEP_END = 3'd4,
        S_FIN      = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_LIMIT    = 2'd0,
        CAUSE_TERMINAL = 2'd1,
        CAUSE_ABORT    = 2'd2
    } cause_t;

    // 1.0 in the unsigned Q0.16 discount domain needs the 17th bit
    localparam logic [16:0] Q16_ONE = 17'h10000;

    // Extract element idx of width w (w <= 32) from a flat belief vector
    function automatic logic [31:0] bel_elem(input logic [1023:0] vec, input int idx, input int w);
        return 32'(vec >> (idx * w)) & ((w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1));
    endfunction

endpackage

// File: rtl/pomdp_reward_acc.sv
// rtl/pomdp_reward_acc.sv - discounted, saturating reward accumulator with running discount
module pomdp_reward_acc
    import pomdp_pkg::*;
#(
    parameter int W_REW = 16,
    parameter int W_ACC = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             acc_en,
    input  logic [15:0]      gamma,
    input  logic             gamma_en,
    input  logic [W_REW-1:0] reward,
    output logic [W_ACC-1:0] acc
);

    localparam int W_PROD = W_REW + 18;
    localparam int W_TERM = W_PROD - 16;

    logic [16:0]              disc;
    logic [16:0]              disc_scaled;
    logic signed [W_PROD-1:0] prod;
    logic signed [W_TERM-1:0] term;
    logic signed [W_ACC:0]    sum;
    logic [W_ACC-1:0]         acc_next;

    always_comb begin
        prod = W_PROD'($signed(reward)) * W_PROD'($signed({1'b0, disc}));
        if (gamma_en) begin
            // arithmetic shift floors toward -inf, so small negative terms stay at -1
            term = W_TERM'(prod >>> 16);
        end else begin
            term = W_TERM'($signed(reward));
        end
        sum = (W_ACC + 1)'($signed(acc)) + (W_ACC + 1)'(term);
        if (sum[W_ACC] != sum[W_ACC-1]) begin
            acc_next = sum[W_ACC] ? {1'b1, {(W_ACC-1){1'b0}}} : {1'b0, {(W_ACC-1){1'b1}}};
        end else begin
            acc_next = sum[W_ACC-1:0];
        end
        disc_scaled = 17'(({16'b0, disc} * {17'b0, gamma}) >> 16);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            disc <= '0;
        end else if (clear) begin
            acc  <= '0;
            disc <= Q16_ONE;
        end else if (acc_en) begin
            acc <= acc_next;
            if (gamma_en) begin
                disc <= disc_scaled;
            end
        end
    end

endmodule

// File: rtl/pomdp_episode_ctrl.sv
// rtl/pomdp_episode_ctrl.sv - episode sequencer: decision, environment and belief engines per step
module pomdp_episode_ctrl
    import pomdp_pkg::*;
#(
    parameter int N_STATE  = 2,
    parameter int N_ACTION = 3,
    parameter int N_OBS    = 2,
    parameter int W_BEL    = 16,
    parameter int W_REW    = 16,
    parameter int W_ACC    = 32,
    parameter int W_STEP   = 16,
    localparam int W_S = (N_STATE > 1) ? $clog2(N_STATE) : 1,
    localparam int W_A = (N_ACTION > 1) ? $clog2(N_ACTION) : 1,
    localparam int W_O = (N_OBS > 1) ? $clog2(N_OBS) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [W_STEP-1:0]        max_steps,
    input  logic [15:0]              gamma,
    input  logic                     gamma_en,
    input  logic [W_S-1:0]           init_state,
    input  logic [N_STATE*W_BEL-1:0] init_belief,
    output logic                     dec_start,
    output logic [N_STATE*W_BEL-1:0] dec_belief,
    input  logic                     dec_done,
    input  logic [W_A-1:0]           dec_action,
    output logic                     env_start,
    input  logic                     env_done,
    input  logic [W_S-1:0]           env_new_state,
    input  logic [W_O-1:0]           env_obs,
    input  logic [W_REW-1:0]         env_reward,
    input  logic                     env_terminal,
    output logic                     bel_start,
    input  logic                     bel_done,
    input  logic [N_STATE*W_BEL-1:0] bel_new_belief,
    output logic [W_S-1:0]           cur_state,
    output logic [W_A-1:0]           action,
    output logic [W_O-1:0]           observation,
    output logic                     busy,
    output logic                     step_valid,
    output logic [W_STEP-1:0]        step_count,
    output logic [W_ACC-1:0]         reward_acc,
    output logic                     done,
    output logic [1:0]               done_cause
);

    state_t            state, state_next;
    cause_t            cause, cause_next;
    logic              entry;
    logic [W_STEP-1:0] max_steps_q;
    logic [W_STEP-1:0] step_inc;
    logic [15:0]       gamma_q;
    logic              gamma_en_q;
    logic [W_S-1:0]    new_state_q;
    logic [W_REW-1:0]  reward_q;
    logic              terminal_q;
    logic              start_load, dec_accept, env_accept, bel_accept, step_commit;

    assign step_inc = (step_count == '1) ? step_count : step_count + W_STEP'(1);

    always_comb begin
        state_next  = state;
        cause_next  = cause;
        start_load  = 1'b0;
        dec_accept  = 1'b0;
        env_accept  = 1'b0;
        bel_accept  = 1'b0;
        step_commit = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    start_load = 1'b1;
                    cause_next = CAUSE_LIMIT;
                    state_next = (max_steps == '0) ? S_FIN : S_DECIDE;
                end
            end
            // a done coinciding with its own start pulse belongs to no request
            S_DECIDE: begin
                if (dec_done && !entry) begin
                    dec_accept = 1'b1;
                    state_next = S_ENV;
                end
            end
            S_ENV: begin
                if (env_done && !entry) begin
                    env_accept = 1'b1;
                    state_next = S_BELIEF;
                end
            end
            S_BELIEF: begin
                if (bel_done && !entry) begin
                    bel_accept = 1'b1;
                    state_next = S_STEP_END;
                end
            end
            S_STEP_END: begin
                step_commit = 1'b1;
                if (terminal_q) begin
                    state_next = S_FIN;
                    cause_next = CAUSE_TERMINAL;
                end else if (step_inc == max_steps_q) begin
                    state_next = S_FIN;
                    cause_next = CAUSE_LIMIT;
                end else begin
                    state_next = S_DECIDE;
                end
            end
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (abort && state != S_IDLE && state != S_FIN) begin
            state_next  = S_FIN;
            cause_next  = CAUSE_ABORT;
            dec_accept  = 1'b0;
            env_accept  = 1'b0;
            bel_accept  = 1'b0;
            step_commit = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cause       <= CAUSE_LIMIT;
            entry       <= 1'b0;
            max_steps_q <= '0;
            gamma_q     <= '0;
            gamma_en_q  <= 1'b0;
            new_state_q <= '0;
            reward_q    <= '0;
            terminal_q  <= 1'b0;
            cur_state   <= '0;
            action      <= '0;
            observation <= '0;
            dec_belief  <= '0;
            step_count  <= '0;
        end else begin
            state <= state_next;
            cause <= cause_next;
            entry <= (state_next != state);
            if (start_load) begin
                max_steps_q <= max_steps;
                gamma_q     <= gamma;
                gamma_en_q  <= gamma_en;
                cur_state   <= init_state;
                dec_belief  <= init_belief;
                step_count  <= '0;
            end
            if (dec_accept) begin
                action <= dec_action;
            end
            // cur_state waits for the belief engine, which needs the pre-transition context
            if (env_accept) begin
                new_state_q <= env_new_state;
                observation <= env_obs;
                reward_q    <= env_reward;
                terminal_q  <= env_terminal;
            end
            if (bel_accept) begin
                dec_belief <= bel_new_belief;
                cur_state  <= new_state_q;
            end
            if (step_commit) begin
                step_count <= step_inc;
            end
        end
    end

    assign dec_start  = (state == S_DECIDE) && entry;
    assign env_start  = (state == S_ENV) && entry;
    assign bel_start  = (state == S_BELIEF) && entry;
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_FIN);
    assign step_valid = step_commit;
    assign done_cause = cause;

    pomdp_reward_acc #(
        .W_REW (W_REW),
        .W_ACC (W_ACC)
    ) u_reward_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (start_load),
        .acc_en   (step_commit),
        .gamma    (gamma_q),
        .gamma_en (gamma_en_q),
        .reward   (reward_q),
        .acc      (reward_acc)
    );

endmodule

// File: tb/tb_pomdp_episode_ctrl.sv
// tb/tb_pomdp_episode_ctrl.sv - directed self-checking bench for pomdp_episode_ctrl
module tb_pomdp_episode_ctrl;
    import pomdp_pkg::*;

    logic        clk, rst_n, start, abort, gamma_en;
    logic [15:0] max_steps, gamma;
    logic [0:0]  init_state;
    logic [31:0] init_belief;
    logic        dec_start, dec_done;
    logic [31:0] dec_belief;
    logic [1:0]  dec_action;
    logic        env_start, env_done, env_terminal;
    logic [0:0]  env_new_state, env_obs;
    logic [15:0] env_reward;
    logic        bel_start, bel_done;
    logic [31:0] bel_new_belief;
    logic [0:0]  cur_state, observation;
    logic [1:0]  action;
    logic        busy, step_valid, done;
    logic [15:0] step_count;
    logic [31:0] reward_acc;
    logic [1:0]  done_cause;

    logic        sat_clear, sat_en, sat_gamma_en;
    logic [15:0] sat_gamma, sat_reward;
    logic [17:0] sat_acc;

    int checks = 0;
    int errors = 0;
    int lat = 1;
    int env_hold_idx = -1;
    bit stray_en = 1'b0;
    int dec_total = 0, env_total = 0, bel_total = 0, step_total = 0, done_total = 0;
    int dec_base = 0, env_base = 0, bel_base = 0, step_base = 0, done_base = 0;
    logic signed [15:0] rew_tab [16];
    logic ns_tab [16];
    logic obs_tab [16];
    logic term_tab [16];

    pomdp_episode_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .max_steps(max_steps), .gamma(gamma), .gamma_en(gamma_en),
        .init_state(init_state), .init_belief(init_belief),
        .dec_start(dec_start), .dec_belief(dec_belief), .dec_done(dec_done), .dec_action(dec_action),
        .env_start(env_start), .env_done(env_done), .env_new_state(env_new_state),
        .env_obs(env_obs), .env_reward(env_reward), .env_terminal(env_terminal),
        .bel_start(bel_start), .bel_done(bel_done), .bel_new_belief(bel_new_belief),
        .cur_state(cur_state), .action(action), .observation(observation),
        .busy(busy), .step_valid(step_valid), .step_count(step_count),
        .reward_acc(reward_acc), .done(done), .done_cause(done_cause)
    );

    pomdp_reward_acc #(.W_REW(16), .W_ACC(18)) u_sat (
        .clk(clk), .rst_n(rst_n), .clear(sat_clear), .acc_en(sat_en),
        .gamma(sat_gamma), .gamma_en(sat_gamma_en), .reward(sat_reward), .acc(sat_acc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (step_valid) step_total++;
            if (done) done_total++;
        end
    end

    initial begin : dec_engine
        int idx;
        dec_done = 1'b0;
        dec_action = '0;
        forever begin
            @(negedge clk);
            dec_done = 1'b0;
            if (dec_start) begin
                idx = dec_total - dec_base;
                dec_total++;
                repeat (lat) @(negedge clk);
                dec_done = 1'b1;
                dec_action = (idx % 2 == 0) ? 2'd1 : 2'd0;
            end else if (stray_en && env_start) begin
                @(negedge clk);
                dec_done = 1'b1;
                dec_action = 2'd2;
            end
        end
    end

    initial begin : env_engine
        int idx;
        env_done = 1'b0;
        env_new_state = '0;
        env_obs = '0;
        env_reward = '0;
        env_terminal = 1'b0;
        forever begin
            @(negedge clk);
            env_done = 1'b0;
            if (env_start) begin
                idx = (env_total - env_base) & 15;
                env_total++;
                if (idx != env_hold_idx) begin
                    repeat (lat) @(negedge clk);
                    env_done = 1'b1;
                    env_new_state = ns_tab[idx];
                    env_obs = obs_tab[idx];
                    env_reward = rew_tab[idx];
                    env_terminal = term_tab[idx];
                end
            end
        end
    end

    initial begin : bel_engine
        int k;
        bel_done = 1'b0;
        bel_new_belief = '0;
        forever begin
            @(negedge clk);
            bel_done = 1'b0;
            if (bel_start) begin
                k = bel_total - bel_base + 1;
                bel_total++;
                repeat (lat) @(negedge clk);
                bel_done = 1'b1;
                bel_new_belief = {16'((k << 12) + 2), 16'((k << 12) + 1)};
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_tabs();
        for (int i = 0; i < 16; i++) begin
            rew_tab[i] = '0;
            ns_tab[i] = 1'b0;
            obs_tab[i] = 1'b0;
            term_tab[i] = 1'b0;
        end
    endtask

    task automatic do_start(input logic [15:0] ms, input logic [15:0] g, input logic ge,
                            input logic s0, input logic [31:0] b0);
        tick();
        dec_base = dec_total;
        env_base = env_total;
        bel_base = bel_total;
        step_base = step_total;
        done_base = done_total;
        max_steps = ms;
        gamma = g;
        gamma_en = ge;
        init_state = s0;
        init_belief = b0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output logic got);
        int n;
        n = 0;
        while (!done && n < 3000) begin
            tick();
            n++;
        end
        got = done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        max_steps = '0;
        gamma = '0;
        gamma_en = 1'b0;
        init_state = '0;
        init_belief = '0;
        sat_clear = 1'b0;
        sat_en = 1'b0;
        sat_gamma = '0;
        sat_gamma_en = 1'b0;
        sat_reward = '0;
        clear_tabs();
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done); end
        checks++; if (step_count !== 16'd0) begin errors++; $display("FAIL reset_step_count got %0d expected 0", step_count); end
        checks++; if (reward_acc !== 32'd0) begin errors++; $display("FAIL reset_reward_acc got %0d expected 0", reward_acc); end
        checks++; if (dec_belief !== 32'd0) begin errors++; $display("FAIL reset_belief got %h expected 0", dec_belief); end
        checks++; if (dec_start !== 1'b0) begin errors++; $display("FAIL reset_dec_start got %b expected 0", dec_start); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_plain_sum();
        logic got;
        logic [1023:0] wide;
        clear_tabs();
        lat = 2;
        rew_tab[0] = 16'sd10; rew_tab[1] = -16'sd4; rew_tab[2] = 16'sd7;
        ns_tab[0] = 1'b1; ns_tab[1] = 1'b0; ns_tab[2] = 1'b1;
        obs_tab[0] = 1'b1; obs_tab[1] = 1'b0; obs_tab[2] = 1'b1;
        do_start(16'd3, 16'h0, 1'b0, 1'b0, 32'h2222_1111);
        checks++; if (dec_belief !== 32'h2222_1111) begin errors++; $display("FAIL plain_init_belief got %h expected 22221111", dec_belief); end
        checks++; if (dec_start !== 1'b1) begin errors++; $display("FAIL plain_first_dec_start got %b expected 1", dec_start); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL plain_busy got %b expected 1", busy); end
        wait_done(got);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL plain_done got %b expected 1", got); end
        checks++; if (reward_acc !== 32'd13) begin errors++; $display("FAIL plain_reward_acc got %0d expected 13", $signed(reward_acc)); end
        checks++; if (step_count !== 16'd3) begin errors++; $display("FAIL plain_step_count got %0d expected 3", step_count); end
        checks++; if (done_cause !== 2'd0) begin errors++; $display("FAIL plain_cause got %0d expected 0", done_cause); end
        checks++; if (step_total - step_base !== 3) begin errors++; $display("FAIL plain_step_pulses got %0d expected 3", step_total - step_base); end
        checks++; if (cur_state !== 1'b1) begin errors++; $display("FAIL plain_cur_state got %0d expected 1", cur_state); end
        checks++; if (action !== 2'd1) begin errors++; $display("FAIL plain_action got %0d expected 1", action); end
        checks++; if (observation !== 1'b1) begin errors++; $display("FAIL plain_obs got %0d expected 1", observation); end
        wide = '0;
        wide[31:0] = dec_belief;
        checks++; if (bel_elem(wide, 0, 16) !== 32'h3001) begin errors++; $display("FAIL plain_belief0 got %h expected 3001", bel_elem(wide, 0, 16)); end
        checks++; if (bel_elem(wide, 1, 16) !== 32'h3002) begin errors++; $display("FAIL plain_belief1 got %h expected 3002", bel_elem(wide, 1, 16)); end
    endtask

    task automatic test_discount();
        logic got;
        clear_tabs();
        lat = 1;
        for (int i = 0; i < 3; i++) rew_tab[i] = 16'sd100;
        do_start(16'd3, 16'h8000, 1'b1, 1'b0, 32'h0);
        wait_done(got);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL disc_done got %b expected 1", got); end
        checks++; if (reward_acc !== 32'd175) begin errors++; $display("FAIL disc_reward_acc got %0d expected 175", $signed(reward_acc)); end
        checks++; if (step_count !== 16'd3) begin errors++; $display("FAIL disc_step_count got %0d expected 3", step_count); end
    endtask

    task automatic test_terminal();
        logic got;
        clear_tabs();
        lat = 1;
        for (int i = 0; i < 16; i++) rew_tab[i] = 16'sd3;
        ns_tab[1] = 1'b1;
        term_tab[1] = 1'b1;
        do_start(16'd10, 16'h0, 1'b0, 1'b0, 32'h0);
        wait_done(got);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL term_done got %b expected 1", got); end
        checks++; if (done_cause !== 2'd1) begin errors++; $display("FAIL term_cause got %0d expected 1", done_cause); end
        checks++; if (step_count !== 16'd2) begin errors++; $display("FAIL term_step_count got %0d expected 2", step_count); end
        checks++; if (cur_state !== 1'b1) begin errors++; $display("FAIL term_cur_state got %0d expected 1", cur_state); end
        checks++; if (reward_acc !== 32'd6) begin errors++; $display("FAIL term_reward_acc got %0d expected 6", $signed(reward_acc)); end
    endtask

    task automatic test_zero_steps();
        clear_tabs();
        lat = 1;
        do_start(16'd0, 16'h0, 1'b0, 1'b0, 32'h0);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done got %b expected 1", done); end
        checks++; if (done_cause !== 2'd0) begin errors++; $display("FAIL zero_cause got %0d expected 0", done_cause); end
        repeat (4) tick();
        checks++; if (dec_total - dec_base !== 0) begin errors++; $display("FAIL zero_dec_starts got %0d expected 0", dec_total - dec_base); end
        checks++; if (env_total - env_base !== 0) begin errors++; $display("FAIL zero_env_starts got %0d expected 0", env_total - env_base); end
        checks++; if (step_count !== 16'd0) begin errors++; $display("FAIL zero_step_count got %0d expected 0", step_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy got %b expected 0", busy); end
    endtask

    task automatic test_abort();
        int n;
        clear_tabs();
        lat = 1;
        rew_tab[0] = 16'sd5;
        rew_tab[1] = 16'sd50;
        env_hold_idx = 1;
        do_start(16'd10, 16'h0, 1'b0, 1'b0, 32'h0);
        n = 0;
        while (env_total - env_base < 2 && n < 500) begin
            tick();
            n++;
        end
        checks++; if (env_total - env_base !== 2) begin errors++; $display("FAIL abort_reach_env got %0d expected 2", env_total - env_base); end
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL abort_done got %b expected 1", done); end
        checks++; if (done_cause !== 2'd2) begin errors++; $display("FAIL abort_cause got %0d expected 2", done_cause); end
        checks++; if (step_count !== 16'd1) begin errors++; $display("FAIL abort_step_count got %0d expected 1", step_count); end
        checks++; if (reward_acc !== 32'd5) begin errors++; $display("FAIL abort_reward_acc got %0d expected 5", $signed(reward_acc)); end
        repeat (5) tick();
        checks++; if (dec_total - dec_base !== 2) begin errors++; $display("FAIL abort_dec_starts got %0d expected 2", dec_total - dec_base); end
        checks++; if (step_total - step_base !== 1) begin errors++; $display("FAIL abort_step_pulses got %0d expected 1", step_total - step_base); end
        abort = 1'b1;
        tick();
        tick();
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle_busy got %b expected 0", busy); end
        checks++; if (done_total - done_base !== 1) begin errors++; $display("FAIL abort_idle_done_pulses got %0d expected 1", done_total - done_base); end
        env_hold_idx = -1;
    endtask

    task automatic test_mid_reset();
        int n;
        clear_tabs();
        lat = 2;
        for (int i = 0; i < 16; i++) rew_tab[i] = 16'sd9;
        for (int i = 0; i < 16; i++) ns_tab[i] = 1'b1;
        do_start(16'd5, 16'h0, 1'b0, 1'b0, 32'h5555_AAAA);
        n = 0;
        while (bel_total - bel_base < 2 && n < 500) begin
            tick();
            n++;
        end
        checks++; if (step_count !== 16'd1) begin errors++; $display("FAIL mrst_pre_step_count got %0d expected 1", step_count); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mrst_busy got %b expected 0", busy); end
        checks++; if (step_count !== 16'd0) begin errors++; $display("FAIL mrst_step_count got %0d expected 0", step_count); end
        checks++; if (reward_acc !== 32'd0) begin errors++; $display("FAIL mrst_reward_acc got %0d expected 0", $signed(reward_acc)); end
        checks++; if (dec_belief !== 32'd0) begin errors++; $display("FAIL mrst_belief got %h expected 0", dec_belief); end
        checks++; if (cur_state !== 1'b0) begin errors++; $display("FAIL mrst_cur_state got %0d expected 0", cur_state); end
        checks++; if (done_cause !== 2'd0) begin errors++; $display("FAIL mrst_cause got %0d expected 0", done_cause); end
        done_base = done_total;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        checks++; if (done_total - done_base !== 0) begin errors++; $display("FAIL mrst_done_pulses got %0d expected 0", done_total - done_base); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mrst_busy_after got %b expected 0", busy); end
    endtask

    task automatic test_stray_done();
        logic got;
        clear_tabs();
        lat = 2;
        for (int i = 0; i < 16; i++) rew_tab[i] = 16'sd1;
        stray_en = 1'b1;
        do_start(16'd2, 16'h0, 1'b0, 1'b0, 32'h0);
        wait_done(got);
        stray_en = 1'b0;
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL stray_done got %b expected 1", got); end
        checks++; if (action !== 2'd0) begin errors++; $display("FAIL stray_action got %0d expected 0", action); end
        checks++; if (step_count !== 16'd2) begin errors++; $display("FAIL stray_step_count got %0d expected 2", step_count); end
        checks++; if (reward_acc !== 32'd2) begin errors++; $display("FAIL stray_reward_acc got %0d expected 2", $signed(reward_acc)); end
        tick();
        checks++; if (dec_total - dec_base !== 2) begin errors++; $display("FAIL stray_dec_starts got %0d expected 2", dec_total - dec_base); end
    endtask

    task automatic test_saturation();
        sat_gamma_en = 1'b0;
        sat_clear = 1'b1;
        tick();
        sat_clear = 1'b0;
        sat_reward = 16'h7FFF;
        sat_en = 1'b1;
        repeat (4) tick();
        checks++; if (sat_acc !== 18'h1FFFC) begin errors++; $display("FAIL sat_pos_4 got %h expected 1fffc", sat_acc); end
        tick();
        checks++; if (sat_acc !== 18'h1FFFF) begin errors++; $display("FAIL sat_pos_clamp got %h expected 1ffff", sat_acc); end
        tick();
        checks++; if (sat_acc !== 18'h1FFFF) begin errors++; $display("FAIL sat_pos_hold got %h expected 1ffff", sat_acc); end
        sat_en = 1'b0;
        sat_clear = 1'b1;
        tick();
        sat_clear = 1'b0;
        sat_reward = 16'h8000;
        sat_en = 1'b1;
        repeat (3) tick();
        checks++; if (sat_acc !== 18'h28000) begin errors++; $display("FAIL sat_neg_3 got %h expected 28000", sat_acc); end
        repeat (2) tick();
        checks++; if (sat_acc !== 18'h20000) begin errors++; $display("FAIL sat_neg_clamp got %h expected 20000", sat_acc); end
        sat_en = 1'b0;
        sat_clear = 1'b1;
        tick();
        sat_clear = 1'b0;
        sat_gamma_en = 1'b1;
        sat_gamma = 16'h8000;
        sat_reward = 16'hFFFF;
        sat_en = 1'b1;
        repeat (3) tick();
        sat_en = 1'b0;
        checks++; if (sat_acc !== 18'h3FFFD) begin errors++; $display("FAIL sat_floor_neg got %h expected 3fffd", sat_acc); end
    endtask

    initial begin
        test_reset();
        test_plain_sum();
        test_discount();
        test_terminal();
        test_zero_steps();
        test_abort();
        test_mid_reset();
        test_stray_done();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
